// File: rtl/bp_be_fp_rec_arbiter.sv
// bp_be_fp_rec_arbiter
//   Lets two FP writeback sources share one combinational fp-to-recoded
//   conversion unit. The sources are the FP load path (ld) and the fmv.x-to-FP
//   move path (mv).
//   Simultaneous requests are arbitrated round-robin. Each converted result is
//   captured, together with its destination tag and source id, into a 2-entry
//   FIFO. That FIFO feeds the FP register file writeback port.
//
//   Optional feature macro: BP_BE_FP_REC_ARB_BYPASS_EN
//     When defined, an accepted request can skip the FIFO. This happens when
//     the FIFO is empty and the writeback consumer is ready; the request then
//     appears on wb_* in the same cycle.
//     When undefined, wb_* are driven purely from FIFO storage.
//
//   Handshake rules (valid/ready, all ports):
//     A transfer happens on a rising clock edge when valid and ready are both
//     high. A producer keeps valid and its payload stable until that transfer.
//     Ready never depends on the producer's valid.
//     For the two request ports, the transfer additionally requires this
//     arbiter's grant. A valid but non-granted source simply holds its request.
module bp_be_fp_rec_arbiter #(
    parameter int dword_width_p  = 64,
    parameter int dp_rec_width_p = 66,
    parameter int tag_width_p    = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      ld_v_i,
    output logic                      ld_ready_o,
    input  logic [dword_width_p-1:0]  ld_data_i,
    input  logic                      ld_sp_not_dp_i,
    input  logic [tag_width_p-1:0]    ld_tag_i,

    input  logic                      mv_v_i,
    output logic                      mv_ready_o,
    input  logic [dword_width_p-1:0]  mv_data_i,
    input  logic                      mv_sp_not_dp_i,
    input  logic [tag_width_p-1:0]    mv_tag_i,

    output logic [dword_width_p-1:0]  conv_raw_o,
    output logic                      conv_raw_sp_not_dp_o,
    input  logic [dp_rec_width_p-1:0] conv_rec_i,
    input  logic                      conv_rec_sp_not_dp_i,

    output logic                      wb_v_o,
    input  logic                      wb_ready_i,
    output logic [dp_rec_width_p-1:0] wb_rec_o,
    output logic                      wb_rec_sp_not_dp_o,
    output logic [tag_width_p-1:0]    wb_tag_o,
    output logic                      wb_src_o
);

    // Source ids, also used as the encoding of last_grant_r.
    localparam logic src_ld = 1'b0;
    localparam logic src_mv = 1'b1;

    // FIFO bookkeeping
    logic [1:0]                fifo_cnt_r;
    logic [1:0]                fifo_cnt_n;
    logic                      wr_ptr_r;
    logic                      rd_ptr_r;
    logic                      last_grant_r;

    // FIFO storage, one field array per entry component
    logic [dp_rec_width_p-1:0] rec_mem_r [2];
    logic [1:0]                sp_mem_r;
    logic [tag_width_p-1:0]    tag_mem_r [2];
    logic [1:0]                src_mem_r;

    // Arbitration and transfer strobes
    logic                      space_avail;
    logic                      grant_ld;
    logic                      grant_mv;
    logic                      accept;
    logic                      enq;
    logic                      deq;
    logic                      fifo_nonempty;
    logic                      bypass;
    logic [tag_width_p-1:0]    acc_tag;
    logic                      acc_src;

    // Space is judged only from the registered count. A dequeue in the same
    // cycle therefore does not open a slot while the FIFO is full.
    // Everything is held off while reset is asserted.
    always_comb begin
        space_avail   = ~reset_i & (fifo_cnt_r < 2'd2);
        fifo_nonempty = (fifo_cnt_r != 2'd0);
    end

    // Round-robin grant. On a tie, the source that did not win last time wins.
    always_comb begin
        grant_ld = space_avail & ld_v_i & (~mv_v_i | (last_grant_r == src_mv));
        grant_mv = space_avail & mv_v_i & (~ld_v_i | (last_grant_r == src_ld));
        accept   = grant_ld | grant_mv;
        acc_src  = grant_mv ? src_mv : src_ld;
        acc_tag  = grant_mv ? mv_tag_i : ld_tag_i;
    end

    assign ld_ready_o = space_avail;
    assign mv_ready_o = space_avail;

    // Steer the granted operand to the conversion unit.
    // With no grant it defaults to the ld inputs; during reset it is forced to 0.
    always_comb begin
        conv_raw_o           = '0;
        conv_raw_sp_not_dp_o = 1'b0;
        if (!reset_i) begin
            if (grant_mv) begin
                conv_raw_o           = mv_data_i;
                conv_raw_sp_not_dp_o = mv_sp_not_dp_i;
            end else begin
                conv_raw_o           = ld_data_i;
                conv_raw_sp_not_dp_o = ld_sp_not_dp_i;
            end
        end
    end

`ifdef BP_BE_FP_REC_ARB_BYPASS_EN
    // An accepted request skips the FIFO when the FIFO is empty and the
    // consumer takes it this cycle.
    always_comb begin
        bypass = accept & ~fifo_nonempty & wb_ready_i;
    end

    // Writeback port: this cycle's conversion result when bypassing, else the
    // FIFO head.
    always_comb begin
        if (bypass) begin
            wb_v_o             = 1'b1;
            wb_rec_o           = conv_rec_i;
            wb_rec_sp_not_dp_o = conv_rec_sp_not_dp_i;
            wb_tag_o           = acc_tag;
            wb_src_o           = acc_src;
        end else begin
            wb_v_o             = fifo_nonempty;
            wb_rec_o           = rec_mem_r[rd_ptr_r];
            wb_rec_sp_not_dp_o = sp_mem_r[rd_ptr_r];
            wb_tag_o           = tag_mem_r[rd_ptr_r];
            wb_src_o           = src_mem_r[rd_ptr_r];
        end
    end
`else
    // No bypass path. Every accepted request goes through the FIFO.
    always_comb begin
        bypass = 1'b0;
    end

    // Writeback port is driven straight from the FIFO head registers.
    always_comb begin
        wb_v_o             = fifo_nonempty;
        wb_rec_o           = rec_mem_r[rd_ptr_r];
        wb_rec_sp_not_dp_o = sp_mem_r[rd_ptr_r];
        wb_tag_o           = tag_mem_r[rd_ptr_r];
        wb_src_o           = src_mem_r[rd_ptr_r];
    end
`endif

    // Push on any accept that was not bypassed. Pop when the head is consumed.
    // When bypassing, the FIFO is empty, so deq is low.
    always_comb begin
        enq = accept & ~bypass;
        deq = fifo_nonempty & wb_ready_i;
    end

    // Next occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        fifo_cnt_n = fifo_cnt_r;
        case ({enq, deq})
            2'b10:   fifo_cnt_n = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_n = fifo_cnt_r - 2'd1;
            default: fifo_cnt_n = fifo_cnt_r;
        endcase
    end

    // Pointer and occupancy registers. The 1-bit pointers wrap naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_cnt_r <= 2'd0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
        end else begin
            fifo_cnt_r <= fifo_cnt_n;
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
        end
    end

    // Round-robin history. It changes only on a grant. It resets to mv so that
    // ld wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant_r <= src_mv;
        end else if (accept) begin
            last_grant_r <= acc_src;
        end
    end

    // FIFO storage write. The entry captures the conversion result together
    // with its destination tag and source id.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rec_mem_r[0] <= '0;
            rec_mem_r[1] <= '0;
            tag_mem_r[0] <= '0;
            tag_mem_r[1] <= '0;
            sp_mem_r     <= 2'b00;
            src_mem_r    <= 2'b00;
        end else if (enq) begin
            rec_mem_r[wr_ptr_r] <= conv_rec_i;
            sp_mem_r[wr_ptr_r]  <= conv_rec_sp_not_dp_i;
            tag_mem_r[wr_ptr_r] <= acc_tag;
            src_mem_r[wr_ptr_r] <= acc_src;
        end
    end

endmodule

// File: tb/tb_bp_be_fp_rec_arbiter.sv
// Bench for bp_be_fp_rec_arbiter in its default build (no bypass).
// A stand-in conversion model is driven from conv_raw_o. Per-cycle vectors
// hold hand-derived expectations. Hand-written sequences cover reset.
module tb_bp_be_fp_rec_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ld_v_i, ld_ready_o, ld_sp_not_dp_i;
    logic [63:0] ld_data_i;
    logic [4:0]  ld_tag_i;
    logic        mv_v_i, mv_ready_o, mv_sp_not_dp_i;
    logic [63:0] mv_data_i;
    logic [4:0]  mv_tag_i;
    logic [63:0] conv_raw_o;
    logic        conv_raw_sp_not_dp_o;
    logic [65:0] conv_rec_i;
    logic        conv_rec_sp_not_dp_i;
    logic        wb_v_o, wb_ready_i, wb_rec_sp_not_dp_o, wb_src_o;
    logic [65:0] wb_rec_o;
    logic [4:0]  wb_tag_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock generation
    always #5 clk_i = ~clk_i;

    bp_be_fp_rec_arbiter dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .ld_v_i               (ld_v_i),
        .ld_ready_o           (ld_ready_o),
        .ld_data_i            (ld_data_i),
        .ld_sp_not_dp_i       (ld_sp_not_dp_i),
        .ld_tag_i             (ld_tag_i),
        .mv_v_i               (mv_v_i),
        .mv_ready_o           (mv_ready_o),
        .mv_data_i            (mv_data_i),
        .mv_sp_not_dp_i       (mv_sp_not_dp_i),
        .mv_tag_i             (mv_tag_i),
        .conv_raw_o           (conv_raw_o),
        .conv_raw_sp_not_dp_o (conv_raw_sp_not_dp_o),
        .conv_rec_i           (conv_rec_i),
        .conv_rec_sp_not_dp_i (conv_rec_sp_not_dp_i),
        .wb_v_o               (wb_v_o),
        .wb_ready_i           (wb_ready_i),
        .wb_rec_o             (wb_rec_o),
        .wb_rec_sp_not_dp_o   (wb_rec_sp_not_dp_o),
        .wb_tag_o             (wb_tag_o),
        .wb_src_o             (wb_src_o)
    );

    // Stand-in conversion unit: an arbitrary but distinctive recoding
    function automatic logic [65:0] rec_model(input logic [63:0] raw, input logic sp);
        return {sp, ~sp, raw ^ 64'h0123_4567_89AB_CDEF};
    endfunction

    always_comb begin
        conv_rec_i           = rec_model(conv_raw_o, conv_raw_sp_not_dp_o);
        conv_rec_sp_not_dp_i = conv_raw_sp_not_dp_o;
    end

    typedef struct {
        logic        ld_v;
        logic [63:0] ld_data;
        logic        ld_sp;
        logic [4:0]  ld_tag;
        logic        mv_v;
        logic [63:0] mv_data;
        logic        mv_sp;
        logic [4:0]  mv_tag;
        logic        wbr;
        logic        e_rdy;
        logic [63:0] e_raw;
        logic        e_wbv;
        logic [4:0]  e_tag;
        logic        e_src;
        logic [65:0] e_rec;
        logic        e_sp;
    } vec_t;

    function automatic vec_t mk(
        input logic ld_v, input logic [63:0] ld_data, input logic ld_sp, input logic [4:0] ld_tag,
        input logic mv_v, input logic [63:0] mv_data, input logic mv_sp, input logic [4:0] mv_tag,
        input logic wbr, input logic e_rdy, input logic [63:0] e_raw, input logic e_wbv,
        input logic [4:0] e_tag, input logic e_src, input logic [65:0] e_rec, input logic e_sp);
        vec_t v;
        v.ld_v = ld_v; v.ld_data = ld_data; v.ld_sp = ld_sp; v.ld_tag = ld_tag;
        v.mv_v = mv_v; v.mv_data = mv_data; v.mv_sp = mv_sp; v.mv_tag = mv_tag;
        v.wbr = wbr; v.e_rdy = e_rdy; v.e_raw = e_raw; v.e_wbv = e_wbv;
        v.e_tag = e_tag; v.e_src = e_src; v.e_rec = e_rec; v.e_sp = e_sp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ld_v_i = v.ld_v; ld_data_i = v.ld_data; ld_sp_not_dp_i = v.ld_sp; ld_tag_i = v.ld_tag;
        mv_v_i = v.mv_v; mv_data_i = v.mv_data; mv_sp_not_dp_i = v.mv_sp; mv_tag_i = v.mv_tag;
        wb_ready_i = v.wbr;
    endtask

    localparam logic [63:0] L1 = 64'hFFFF_FFFF_3F80_0000;
    localparam logic [63:0] L2 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] L3 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] L4 = 64'hC008_0000_0000_0000;
    localparam logic [63:0] M2 = 64'h0000_0000_4049_0FDB;
    localparam logic [63:0] M3 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] M4 = 64'hFFFF_FFFF_C000_0000;
    localparam logic [63:0] M5 = 64'h7FF8_0000_0000_0000;

    vec_t vecs[19];

    initial begin
        // Vector table, one entry per cycle
        // tie: grants ld, mv, ld, mv; writeback sources 0,1,0,1
        vecs[0]  = mk(1, L2, 0, 1, 1, M2, 1, 9, 1, 1, L2, 0, 0, 0, '0, 0);
        vecs[1]  = mk(1, L2, 0, 1, 1, M2, 1, 9, 1, 1, M2, 1, 1, 0, rec_model(L2, 0), 0);
        vecs[2]  = mk(1, L2, 0, 1, 1, M2, 1, 9, 1, 1, L2, 1, 9, 1, rec_model(M2, 1), 1);
        vecs[3]  = mk(1, L2, 0, 1, 1, M2, 1, 9, 1, 1, M2, 1, 1, 0, rec_model(L2, 0), 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 9, 1, rec_model(M2, 1), 1);
        // single ld: one-cycle latency to writeback
        vecs[5]  = mk(1, L1, 1, 3, 0, 0, 0, 0, 1, 1, L1, 0, 0, 0, '0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 3, 0, rec_model(L1, 1), 1);
        // backpressure: two accepts, then ready drops; drain in order
        vecs[7]  = mk(1, L3, 0, 5, 0, 0, 0, 0, 0, 1, L3, 0, 0, 0, '0, 0);
        vecs[8]  = mk(1, L4, 0, 6, 0, 0, 0, 0, 0, 1, L4, 1, 5, 0, rec_model(L3, 0), 0);
        vecs[9]  = mk(1, L4, 0, 6, 0, 0, 0, 0, 0, 0, L4, 1, 5, 0, rec_model(L3, 0), 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5, 0, rec_model(L3, 0), 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 6, 0, rec_model(L4, 0), 0);
        // full with simultaneous dequeue: mv held, accepted next cycle
        vecs[12] = mk(0, 0, 0, 0, 1, M3, 0, 12, 0, 1, M3, 0, 0, 0, '0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, M4, 1, 13, 0, 1, M4, 1, 12, 1, rec_model(M3, 0), 0);
        vecs[14] = mk(0, 0, 0, 0, 1, M5, 0, 14, 1, 0, 0, 1, 12, 1, rec_model(M3, 0), 0);
        vecs[15] = mk(0, 0, 0, 0, 1, M5, 0, 14, 0, 1, M5, 1, 13, 1, rec_model(M4, 1), 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 13, 1, rec_model(M4, 1), 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 14, 1, rec_model(M5, 0), 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0, 0);

        // Reset state, with live ld inputs that must not leak through
        reset_i = 1'b1;
        drive(mk(1, L1, 1, 3, 1, M3, 0, 7, 1, 0, 0, 0, 0, 0, '0, 0));
        #2;
        chk("reset_wb_v", {65'd0, wb_v_o}, 66'd0);
        chk("reset_ld_ready", {65'd0, ld_ready_o}, 66'd0);
        chk("reset_mv_ready", {65'd0, mv_ready_o}, 66'd0);
        chk("reset_conv_raw", {2'b00, conv_raw_o}, 66'd0);
        chk("reset_wb_rec", wb_rec_o, 66'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0;

        // Table loop
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            @(negedge clk_i);
            chk($sformatf("v%0d_ld_ready", i), {65'd0, ld_ready_o}, {65'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_mv_ready", i), {65'd0, mv_ready_o}, {65'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_conv_raw", i), {2'b00, conv_raw_o}, {2'b00, vecs[i].e_raw});
            chk($sformatf("v%0d_wb_v", i), {65'd0, wb_v_o}, {65'd0, vecs[i].e_wbv});
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d_wb_tag", i), {61'd0, wb_tag_o}, {61'd0, vecs[i].e_tag});
                chk($sformatf("v%0d_wb_src", i), {65'd0, wb_src_o}, {65'd0, vecs[i].e_src});
                chk($sformatf("v%0d_wb_rec", i), wb_rec_o, vecs[i].e_rec);
                chk($sformatf("v%0d_wb_sp", i), {65'd0, wb_rec_sp_not_dp_o}, {65'd0, vecs[i].e_sp});
            end
            @(posedge clk_i); #1;
        end

        // Reset mid-operation: fill with two ld entries (last grant = ld), then pulse reset
        drive(mk(1, L1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0));
        @(posedge clk_i); #1;
        drive(mk(1, L2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0));
        @(posedge clk_i); #1;
        drive(mk(1, L3, 0, 5, 1, M3, 0, 12, 0, 0, 0, 0, 0, 0, '0, 0));
        #1;
        chk("full_wb_v", {65'd0, wb_v_o}, 66'd1);
        chk("full_ld_ready", {65'd0, ld_ready_o}, 66'd0);
        chk("full_wb_tag", {61'd0, wb_tag_o}, 66'd3);
        #1 reset_i = 1'b1;
        #1;
        chk("midrst_wb_v", {65'd0, wb_v_o}, 66'd0);
        chk("midrst_ld_ready", {65'd0, ld_ready_o}, 66'd0);
        chk("midrst_mv_ready", {65'd0, mv_ready_o}, 66'd0);
        chk("midrst_conv_raw", {2'b00, conv_raw_o}, 66'd0);
        chk("midrst_wb_tag", {61'd0, wb_tag_o}, 66'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("postrst_wb_v", {65'd0, wb_v_o}, 66'd0);
        chk("postrst_ld_ready", {65'd0, ld_ready_o}, 66'd1);
        chk("postrst_tie_ld", {2'b00, conv_raw_o}, {2'b00, L3});
        @(posedge clk_i); #1;
        chk("postrst_wb_v1", {65'd0, wb_v_o}, 66'd1);
        chk("postrst_wb_src", {65'd0, wb_src_o}, 66'd0);
        chk("postrst_wb_tag", {61'd0, wb_tag_o}, 66'd5);
        chk("postrst_wb_rec", wb_rec_o, rec_model(L3, 0));
        chk("postrst_tie_mv", {2'b00, conv_raw_o}, {2'b00, M3});
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0, 0));
        repeat (3) @(posedge clk_i);
        #1;
        chk("drain_wb_v", {65'd0, wb_v_o}, 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
